fetch_unit: RTL and testbench

Instruction-fetch initiator for the pipelined LC-3b datapath. It owns the fetch PC, issues word reads on the instruction-memory port, and drives the `load`/`resp`/`flush` controls and data input of the downstream instruction register. It captures an instruction that returns while the pipeline is stalled, then delivers it when the stall ends. It also handles branch/trap redirects, including redirects that arrive while a memory read is still outstanding.

---
 rtl/fetch_unit_if.sv | 11 +
 rtl/fetch_unit.sv | 178 +++++++++++++++++
 tb/tb_fetch_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory port of the LC-3b fetch unit.
// The fetch unit is the master; the instruction memory is the slave.
interface fetch_unit_if;
  logic        read;
  logic [15:0] address;
  logic [15:0] rdata;
  logic        resp;

  modport master (output read, output address, input rdata, input resp);
  modport slave  (input read, input address, output rdata, output resp);
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator for the pipelined LC-3b datapath.
// Optional macro FETCH_PREFETCH_EN adds a second hold entry that is filled by prefetching during a stall.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               redirect,
  input  logic [15:0]        redirect_pc,
  fetch_unit_if.master       imem,
  output logic               ir_load,
  output logic               ir_resp,
  output logic               ir_flush,
  output logic [15:0]        ir_in,
  output logic [15:0]        ir_pc
);

  typedef enum logic [1:0] {START, FETCH, DISCARD, HOLD} state_t;

  state_t      state;
  logic [15:0] pc;
  logic [15:0] addr_reg;
  logic [15:0] hold_data;
  logic [15:0] hold_pc;
  logic [15:0] target;
  logic [15:0] pc_inc;
  logic        hold_read;
  logic        deliver_fetch;
  logic        deliver_hold;

  assign target = redirect_pc & 16'hFFFE;
  assign pc_inc = pc + 16'd2;

`ifdef FETCH_PREFETCH_EN
  logic [15:0] pf_data;
  logic [15:0] pf_pc;
  logic        pf_valid;
  logic        pend;
  logic        hold_resp;

  // Keep reading while the spare entry is empty; finish any read already on the bus.
  assign hold_read = !pf_valid && (stall || pend);
  assign hold_resp = (state == HOLD) && hold_read && imem.resp;
`else
  assign hold_read = 1'b0;
`endif

  assign imem.read    = (state == FETCH) || (state == DISCARD) ||
                        ((state == HOLD) && hold_read);
  assign imem.address = addr_reg;

  assign deliver_fetch = (state == FETCH) && imem.resp && !redirect && !stall;
  assign deliver_hold  = (state == HOLD) && !redirect && !stall;

  assign ir_load  = deliver_fetch || deliver_hold;
  assign ir_in    = (state == HOLD) ? hold_data : imem.rdata;
  assign ir_resp  = stall && reset_n;
  assign ir_flush = redirect && reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= START;
      pc        <= RESET_PC;
      addr_reg  <= RESET_PC;
      ir_pc     <= 16'h0000;
      hold_data <= 16'h0000;
      hold_pc   <= 16'h0000;
`ifdef FETCH_PREFETCH_EN
      pf_data   <= 16'h0000;
      pf_pc     <= 16'h0000;
      pf_valid  <= 1'b0;
      pend      <= 1'b0;
`endif
    end else begin
      if (ir_load)
        ir_pc <= (state == HOLD) ? hold_pc : addr_reg;

      case (state)
        START: begin
          state <= FETCH;
          if (redirect) begin
            pc       <= target;
            addr_reg <= target;
          end
        end

        FETCH: begin
          if (redirect) begin
            pc <= target;
            // A read with no response yet must run to completion at its old address.
            if (imem.resp)
              addr_reg <= target;
            else
              state <= DISCARD;
          end else if (imem.resp) begin
            pc       <= pc_inc;
            addr_reg <= pc_inc;
            if (stall) begin
              hold_data <= imem.rdata;
              hold_pc   <= addr_reg;
              state     <= HOLD;
`ifdef FETCH_PREFETCH_EN
              pf_valid  <= 1'b0;
              pend      <= 1'b0;
`endif
            end
          end
        end

        DISCARD: begin
          if (imem.resp) begin
            state <= FETCH;
            if (redirect) begin
              pc       <= target;
              addr_reg <= target;
            end else begin
              addr_reg <= pc;
            end
          end else if (redirect) begin
            pc <= target;
          end
        end

        HOLD: begin
`ifdef FETCH_PREFETCH_EN
          if (redirect) begin
            pc       <= target;
            pf_valid <= 1'b0;
            pend     <= 1'b0;
            if (hold_read && !imem.resp) begin
              state <= DISCARD;
            end else begin
              addr_reg <= target;
              state    <= FETCH;
            end
          end else begin
            pend <= hold_read && !imem.resp;
            if (hold_resp) begin
              pc       <= pc_inc;
              addr_reg <= pc_inc;
            end
            if (!stall) begin
              if (pf_valid) begin
                hold_data <= pf_data;
                hold_pc   <= pf_pc;
                pf_valid  <= 1'b0;
              end else if (hold_resp) begin
                hold_data <= imem.rdata;
                hold_pc   <= addr_reg;
              end else begin
                // An outstanding read simply continues in FETCH at the same address.
                state <= FETCH;
                pend  <= 1'b0;
              end
            end else if (hold_resp) begin
              pf_data  <= imem.rdata;
              pf_pc    <= addr_reg;
              pf_valid <= 1'b1;
            end
          end
`else
          if (redirect) begin
            pc       <= target;
            addr_reg <= target;
            state    <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
`endif
        end

        default: state <= START;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; the bench plays the instruction memory cycle by cycle.
// Memory data for address A is 16'h1000 + A unless a vector says otherwise.
module tb_fetch_unit;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [15:0] rpc;
    logic        resp;
    logic [15:0] rdata;
    logic        e_read;
    logic [15:0] e_addr;
    logic        e_load;
    logic [15:0] e_in;
    logic        e_flush;
    logic [15:0] e_pc;
  } vec_t;

`ifdef FETCH_PREFETCH_EN
  localparam logic PF = 1'b1;
`else
  localparam logic PF = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_load;
  logic        ir_resp;
  logic        ir_flush;
  logic [15:0] ir_in;
  logic [15:0] ir_pc;

  int n_compared;
  int n_mismatched;

  vec_t vecs[$];

  fetch_unit_if imem_bus ();

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (imem_bus),
    .ir_load     (ir_load),
    .ir_resp     (ir_resp),
    .ir_flush    (ir_flush),
    .ir_in       (ir_in),
    .ir_pc       (ir_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input logic s, input logic r, input logic [15:0] rp,
                        input logic rs, input logic [15:0] rd,
                        input logic er, input logic [15:0] ea,
                        input logic el, input logic [15:0] ei,
                        input logic ef, input logic [15:0] ep);
    vec_t v;
    v.stall = s; v.redirect = r; v.rpc = rp; v.resp = rs; v.rdata = rd;
    v.e_read = er; v.e_addr = ea; v.e_load = el; v.e_in = ei;
    v.e_flush = ef; v.e_pc = ep;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drives one cycle of inputs on the falling edge and lets combinational outputs settle.
  task automatic applyStimulus(input logic s, input logic r, input logic [15:0] rp,
                               input logic rs, input logic [15:0] rd);
    @(negedge clk);
    stall         = s;
    redirect      = r;
    redirect_pc   = rp;
    imem_bus.resp = rs;
    imem_bus.rdata = rd;
    #1;
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    checkOutput({tag, " imem_read"}, {15'd0, imem_bus.read}, {15'd0, v.e_read});
    if (v.e_read)
      checkOutput({tag, " imem_address"}, imem_bus.address, v.e_addr);
    checkOutput({tag, " ir_load"}, {15'd0, ir_load}, {15'd0, v.e_load});
    if (v.e_load)
      checkOutput({tag, " ir_in"}, ir_in, v.e_in);
    checkOutput({tag, " ir_resp"}, {15'd0, ir_resp}, {15'd0, v.stall});
    checkOutput({tag, " ir_flush"}, {15'd0, ir_flush}, {15'd0, v.e_flush});
    checkOutput({tag, " ir_pc"}, ir_pc, v.e_pc);
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    reset_n       = 1'b0;
    stall         = 1'b0;
    redirect      = 1'b0;
    redirect_pc   = 16'h0000;
    imem_bus.resp = 1'b0;
    imem_bus.rdata = 16'h0000;

    //      stall redir rpc      resp rdata     read addr     load in        flush ir_pc
    addVec(0, 0, 16'h0000, 1, 16'h1000,  1, 16'h0000, 1, 16'h1000, 0, 16'h0000);
    addVec(0, 0, 16'h0000, 1, 16'h1002,  1, 16'h0002, 1, 16'h1002, 0, 16'h0000);
    addVec(0, 0, 16'h0000, 1, 16'h1004,  1, 16'h0004, 1, 16'h1004, 0, 16'h0002);
    addVec(1, 0, 16'h0000, 1, 16'h1006,  1, 16'h0006, 0, 16'h0000, 0, 16'h0004);
    addVec(1, 0, 16'h0000, 0, 16'h0000, PF, 16'h0008, 0, 16'h0000, 0, 16'h0004);
    addVec(1, 0, 16'h0000, 0, 16'h0000, PF, 16'h0008, 0, 16'h0000, 0, 16'h0004);
    addVec(0, 0, 16'h0000, 0, 16'h0000, PF, 16'h0008, 1, 16'h1006, 0, 16'h0004);
    addVec(0, 0, 16'h0000, 1, 16'h1008,  1, 16'h0008, 1, 16'h1008, 0, 16'h0006);
    addVec(0, 0, 16'h0000, 1, 16'h100A,  1, 16'h000A, 1, 16'h100A, 0, 16'h0008);
    addVec(0, 0, 16'h0000, 1, 16'h100C,  1, 16'h000C, 1, 16'h100C, 0, 16'h000A);
    addVec(0, 0, 16'h0000, 1, 16'h100E,  1, 16'h000E, 1, 16'h100E, 0, 16'h000C);
    addVec(0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0010, 0, 16'h0000, 0, 16'h000E);
    addVec(0, 1, 16'h4000, 0, 16'h0000,  1, 16'h0010, 0, 16'h0000, 1, 16'h000E);
    addVec(0, 0, 16'h0000, 0, 16'h0000,  1, 16'h0010, 0, 16'h0000, 0, 16'h000E);
    addVec(0, 0, 16'h0000, 1, 16'h1010,  1, 16'h0010, 0, 16'h0000, 0, 16'h000E);
    addVec(0, 0, 16'h0000, 1, 16'h5000,  1, 16'h4000, 1, 16'h5000, 0, 16'h000E);
    addVec(1, 1, 16'hFFFE, 1, 16'h5002,  1, 16'h4002, 0, 16'h0000, 1, 16'h4000);
    addVec(0, 0, 16'h0000, 1, 16'h0FFE,  1, 16'hFFFE, 1, 16'h0FFE, 0, 16'h4000);
    addVec(0, 0, 16'h0000, 1, 16'h1000,  1, 16'h0000, 1, 16'h1000, 0, 16'hFFFE);
    addVec(0, 1, 16'h1235, 1, 16'h1002,  1, 16'h0002, 0, 16'h0000, 1, 16'h0000);
    addVec(0, 0, 16'h0000, 1, 16'h2234,  1, 16'h1234, 1, 16'h2234, 0, 16'h0000);
    addVec(1, 0, 16'h0000, 1, 16'h2236,  1, 16'h1236, 0, 16'h0000, 0, 16'h1234);
    addVec(0, 1, 16'h2000, 0, 16'h0000,  0, 16'h0000, 0, 16'h0000, 1, 16'h1234);
    addVec(0, 0, 16'h0000, 1, 16'h3000,  1, 16'h2000, 1, 16'h3000, 0, 16'h1234);
    addVec(0, 1, 16'h3000, 0, 16'h0000,  1, 16'h2002, 0, 16'h0000, 1, 16'h2000);
    addVec(0, 1, 16'h3100, 0, 16'h0000,  1, 16'h2002, 0, 16'h0000, 1, 16'h2000);
    addVec(0, 0, 16'h0000, 1, 16'h3002,  1, 16'h2002, 0, 16'h0000, 0, 16'h2000);
    addVec(0, 0, 16'h0000, 1, 16'h4100,  1, 16'h3100, 1, 16'h4100, 0, 16'h2000);
    addVec(0, 0, 16'h0000, 0, 16'h0000,  1, 16'h3102, 0, 16'h0000, 0, 16'h3100);

    // Outputs stay quiet in reset even with stall and redirect raised.
    applyStimulus(1, 1, 16'h1234, 1, 16'hBEEF);
    checkOutput("reset imem_read", {15'd0, imem_bus.read}, 16'd0);
    checkOutput("reset ir_load",   {15'd0, ir_load},       16'd0);
    checkOutput("reset ir_resp",   {15'd0, ir_resp},       16'd0);
    checkOutput("reset ir_flush",  {15'd0, ir_flush},      16'd0);
    checkOutput("reset ir_pc",     ir_pc,                  16'h0000);

    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    reset_n = 1'b1;
    #1;
    checkOutput("start imem_read", {15'd0, imem_bus.read}, 16'd0);
    checkOutput("start ir_load",   {15'd0, ir_load},       16'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].stall, vecs[i].redirect, vecs[i].rpc, vecs[i].resp, vecs[i].rdata);
      checkVector($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while the read to 16'h3102 is outstanding, with a late response pulse during reset.
    @(negedge clk);
    imem_bus.resp = 1'b0;
    reset_n = 1'b0;
    #1;
    checkOutput("midreset imem_read", {15'd0, imem_bus.read}, 16'd0);
    checkOutput("midreset ir_load",   {15'd0, ir_load},       16'd0);
    applyStimulus(0, 0, 16'h0000, 1, 16'h9999);
    checkOutput("midreset resp ir_load", {15'd0, ir_load}, 16'd0);
    checkOutput("midreset ir_pc",        ir_pc,            16'h0000);
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    reset_n = 1'b1;
    #1;
    checkOutput("postreset start read", {15'd0, imem_bus.read}, 16'd0);
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    checkOutput("postreset read",    {15'd0, imem_bus.read}, 16'd1);
    checkOutput("postreset address", imem_bus.address,       16'h0000);
    checkOutput("postreset ir_load", {15'd0, ir_load},       16'd0);

`ifdef FETCH_PREFETCH_EN
    // Two words captured during a stall are delivered back to back with the bus idle.
    applyStimulus(1, 0, 16'h0000, 1, 16'h1000);
    checkOutput("pf capture ir_load", {15'd0, ir_load}, 16'd0);
    applyStimulus(1, 0, 16'h0000, 1, 16'h1002);
    checkOutput("pf prefetch read",    {15'd0, imem_bus.read}, 16'd1);
    checkOutput("pf prefetch address", imem_bus.address,       16'h0002);
    applyStimulus(1, 0, 16'h0000, 0, 16'h0000);
    checkOutput("pf full read", {15'd0, imem_bus.read}, 16'd0);
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    checkOutput("pf first read",    {15'd0, imem_bus.read}, 16'd0);
    checkOutput("pf first ir_load", {15'd0, ir_load},       16'd1);
    checkOutput("pf first ir_in",   ir_in,                  16'h1000);
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    checkOutput("pf second read",    {15'd0, imem_bus.read}, 16'd0);
    checkOutput("pf second ir_load", {15'd0, ir_load},       16'd1);
    checkOutput("pf second ir_in",   ir_in,                  16'h1002);
    checkOutput("pf second ir_pc",   ir_pc,                  16'h0000);
    applyStimulus(0, 0, 16'h0000, 0, 16'h0000);
    checkOutput("pf resume read",    {15'd0, imem_bus.read}, 16'd1);
    checkOutput("pf resume address", imem_bus.address,       16'h0004);
    checkOutput("pf resume ir_pc",   ir_pc,                  16'h0002);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
